// File: rtl/hilo_unit.sv
// hilo_unit
// HI/LO register pair for a multi-cycle multiplier. A multu pulse starts a
// fixed-latency wait. After MUL_LAT rising edges the 64-bit product is
// captured into hi (upper word) and lo (lower word). While the multiply is in
// flight, the unit ignores moves into HI/LO and postpones reads. It raises
// stall so that the requester holds its request until the capture is done.
//
// Ports
//   clk     : single clock, rising edge
//   reset   : asynchronous, active-low reset
//   multu   : start pulse (same signal that launches the multiplier)
//   prod    : 64-bit multiplier product, valid by the capture edge
//   mfhi    : read request for HI
//   mflo    : read request for LO
//   mthi    : write request for HI
//   mtlo    : write request for LO
//   wdata   : write data for mthi/mtlo
//   hi, lo  : architectural HI and LO registers
//   rdata   : registered read data
//   rvalid  : one-cycle pulse, rdata valid
//   busy    : multiply in flight
//   stall   : combinational pipeline freeze request
//
// FSM
//   state | meaning
//   IDLE  | no multiply pending; reads and writes of HI/LO are serviced
//   WAIT  | multiply in flight; cnt counts down to the capture edge

module hilo_unit #(
  parameter int MUL_LAT = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        multu,
  input  logic [63:0] prod,
  input  logic        mfhi,
  input  logic        mflo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        stall
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // The count runs from MUL_LAT-1 down to 0, and one more edge is spent on
  // the capture. The capture therefore lands exactly MUL_LAT edges after the
  // start edge.
  localparam logic [5:0] CNT_LOAD = 6'(MUL_LAT - 1);

  state_t     state;
  logic [5:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      rdata  <= 32'd0;
      rvalid <= 1'b0;
      busy   <= 1'b0;
    end else begin
      rvalid <= 1'b0;

      // multu wins in either state. In WAIT it restarts the count, so the
      // product of the abandoned multiply is never captured.
      if (multu) begin
        state <= WAIT;
        cnt   <= CNT_LOAD;
        busy  <= 1'b1;
      end else if (state == WAIT) begin
        if (cnt != 6'd0) begin
          cnt <= cnt - 6'd1;
        end else begin
          hi    <= prod[63:32];
          lo    <= prod[31:0];
          state <= IDLE;
          busy  <= 1'b0;
        end
      end

      // Moves and reads are serviced only when no multiply is in flight. The
      // capture branch above only fires while busy is set, so it never
      // competes with these writes. A read sees the pre-edge hi/lo, which
      // gives read-before-write when both touch the same register. A read
      // held through a stall completes on the first edge with busy low. That
      // edge follows the capture edge, so the read returns the captured
      // value.
      if (!busy) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
        if (mfhi) begin
          rdata  <= hi;
          rvalid <= 1'b1;
        end else if (mflo) begin
          rdata  <= lo;
          rvalid <= 1'b1;
        end
      end
    end
  end

  assign stall = busy & (mfhi | mflo | mthi | mtlo);

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit
// Directed bench for hilo_unit. It drives inputs 1 time unit after each
// rising edge and samples outputs at the same point. Expected values are
// worked out by hand from the product inputs the bench supplies.

module tb_hilo_unit;

  logic        clk;
  logic        reset;
  logic        multu;
  logic [63:0] prod;
  logic        mfhi, mflo, mthi, mtlo;
  logic [31:0] wdata;
  logic [31:0] hi, lo, rdata;
  logic        rvalid, busy, stall;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;

  hilo_unit #(.MUL_LAT(33)) dut (
    .clk    (clk),
    .reset  (reset),
    .multu  (multu),
    .prod   (prod),
    .mfhi   (mfhi),
    .mflo   (mflo),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .hi     (hi),
    .lo     (lo),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy),
    .stall  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset asserted with random inputs: every output must stay cleared
    reset = 1'b0;
    multu = 1'($urandom); mfhi = 1'($urandom); mflo = 1'($urandom);
    mthi  = 1'($urandom); mtlo = 1'($urandom);
    wdata = $urandom; prod = {$urandom, $urandom};
    tick();
    multu = 1'b1; mfhi = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
    tick();
    tick();
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    check1("rst_rvalid", rvalid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_stall", stall, 1'b0);

    multu = 1'b0; mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wdata = 32'd0; prod = 64'd0;
    reset = 1'b1;
    tick();
    check1("post_rst_busy", busy, 1'b0);
    check32("post_rst_hi", hi, 32'd0);

    // 3*5: the product only becomes valid shortly before the capture
    multu = 1'b1; prod = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    multu = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= 33; k++) begin
      if (busy) busy_cnt++;
      if (k == 32) prod = 64'd15;
      if (k == 33) check32("m1_no_early_lo", lo, 32'd0);
      tick();
    end
    check32("m1_busy_cycles", 32'(busy_cnt), 32'd33);
    check1("m1_busy_done", busy, 1'b0);
    check32("m1_hi", hi, 32'h0000_0000);
    check32("m1_lo", lo, 32'h0000_000F);
    mflo = 1'b1;
    tick();
    mflo = 1'b0;
    check32("m1_mflo_rdata", rdata, 32'h0000_000F);
    check1("m1_mflo_rvalid", rvalid, 1'b1);
    tick();
    check1("m1_rvalid_pulse", rvalid, 1'b0);
    check32("m1_rdata_hold", rdata, 32'h0000_000F);

    // 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001
    multu = 1'b1; prod = 64'hFFFF_FFFE_0000_0001;
    tick();
    multu = 1'b0;
    repeat (32) tick();
    check1("m2_busy_e32", busy, 1'b1);
    check32("m2_lo_e32", lo, 32'h0000_000F);
    tick();
    check1("m2_busy_e33", busy, 1'b0);
    check32("m2_hi", hi, 32'hFFFF_FFFE);
    check32("m2_lo", lo, 32'h0000_0001);

    // mfhi held from cycle 5 of a multiply: stalled until busy falls
    multu = 1'b1; prod = 64'h0000_0003_0000_0000;
    tick();
    multu = 1'b0;
    repeat (5) tick();
    mfhi = 1'b1;
    #1;
    for (int k = 5; k <= 32; k++) begin
      check1("m3_stall", stall, 1'b1);
      check1("m3_rvalid_low", rvalid, 1'b0);
      tick();
    end
    check32("m3_rdata_held", rdata, 32'h0000_000F);
    check1("m3_busy_cap", busy, 1'b0);
    check1("m3_stall_cap", stall, 1'b0);
    check1("m3_rvalid_cap", rvalid, 1'b0);
    check32("m3_hi", hi, 32'h0000_0003);
    tick();
    check1("m3_rvalid", rvalid, 1'b1);
    check32("m3_rdata", rdata, 32'h0000_0003);
    mfhi = 1'b0;
    tick();
    check1("m3_rvalid_end", rvalid, 1'b0);

    // Restart at cnt=22, plus an mthi during WAIT that must be ignored
    multu = 1'b1; prod = 64'h1111_1111_2222_2222;
    tick();
    multu = 1'b0;
    repeat (3) tick();
    mthi = 1'b1; wdata = 32'h1234_5678;
    #1;
    check1("m4_stall_mthi", stall, 1'b1);
    tick();
    mthi = 1'b0;
    check32("m4_mthi_ignored", hi, 32'h0000_0003);
    repeat (6) tick();
    multu = 1'b1;
    tick();
    multu = 1'b0;
    repeat (22) tick();
    check1("m4_busy_old33", busy, 1'b1);
    check32("m4_hi_old33", hi, 32'h0000_0003);
    check32("m4_lo_old33", lo, 32'h0000_0000);
    prod = 64'h0000_0000_0000_003F;
    repeat (10) tick();
    check1("m4_busy_s32", busy, 1'b1);
    tick();
    check1("m4_busy_s33", busy, 1'b0);
    check32("m4_hi", hi, 32'h0000_0000);
    check32("m4_lo", lo, 32'h0000_003F);

    // One-cycle reset in WAIT cycle 20 aborts the multiply
    multu = 1'b1; prod = 64'hCAFE_BABE_0BAD_F00D;
    tick();
    multu = 1'b0;
    repeat (20) tick();
    reset = 1'b0;
    #1;
    check1("m5_busy_async", busy, 1'b0);
    check32("m5_hi_async", hi, 32'd0);
    check32("m5_lo_async", lo, 32'd0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    check1("m5_busy_e33", busy, 1'b0);
    check32("m5_hi_e33", hi, 32'd0);
    check32("m5_lo_e33", lo, 32'd0);
    tick();
    check32("m5_lo_e34", lo, 32'd0);

    // IDLE moves, read-before-write, mfhi priority
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1111_1111;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check32("w_hi", hi, 32'h1111_1111);
    check32("w_lo", lo, 32'h1111_1111);
    mfhi = 1'b1; mflo = 1'b1; mthi = 1'b1; wdata = 32'h2222_2222;
    tick();
    mthi = 1'b0;
    check32("rbw_rdata", rdata, 32'h1111_1111);
    check1("rbw_rvalid", rvalid, 1'b1);
    check32("rbw_hi", hi, 32'h2222_2222);
    check32("rbw_lo", lo, 32'h1111_1111);
    tick();
    mfhi = 1'b0; mflo = 1'b0;
    check32("prio_rdata", rdata, 32'h2222_2222);
    mflo = 1'b1;
    tick();
    mflo = 1'b0;
    check32("mflo_rdata", rdata, 32'h1111_1111);

    // Moves together with multu in IDLE: write now, capture overwrites later
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_5555;
    multu = 1'b1; prod = 64'h0000_0001_0000_0002;
    tick();
    mthi = 1'b0; mtlo = 1'b0; multu = 1'b0;
    check32("wm_hi", hi, 32'hAAAA_5555);
    check32("wm_lo", lo, 32'hAAAA_5555);
    check1("wm_busy", busy, 1'b1);
    repeat (33) tick();
    check1("wm_busy_done", busy, 1'b0);
    check32("wm_hi_cap", hi, 32'h0000_0001);
    check32("wm_lo_cap", lo, 32'h0000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
